// File: rtl/led_pkg.sv
// Shared types and constants for the multiplexed LED scan controller.
// Optional leading-zero suppression in the controller is enabled by defining
// LED_LEADING_ZERO_BLANK_EN.
package led_pkg;

  // Scan FSM: BLANK holds every digit off, DRIVE lights the selected digit.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Segment vector in the conventional g..a order, so bit 0 is segment a.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg7_t;

  localparam seg7_t SEG_OFF = '0;

  // Standard 7-segment patterns for hex 0-F (A, b, C, d, E, F for 10-15).
  localparam seg7_t HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Ceiling log2, usable in constant expressions; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/led_hex_decoder.sv
// Purely combinational 4-bit hex to 7-segment decoder.
module led_hex_decoder
  import led_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  // Table lookup of the standard hex glyph.
  always_comb begin
    seg = HEX_SEG_TABLE[hex];
  end

endmodule

// File: rtl/led_scan_controller.sv
// Multiplexed common-cathode LED scan controller.
// Scans NUM_DIGITS digits with DWELL_CYCLES of drive and BLANK_CYCLES of
// all-off gap per digit. New contents are committed only at frame boundaries
// through a Load/LoadAck handshake, so a frame is never torn.
// Define LED_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module led_scan_controller
  import led_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    Enable,
  input  logic [4*NUM_DIGITS-1:0] DigitData,
  input  logic [NUM_DIGITS-1:0]   DPMask,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  input  logic                    Load,
  output logic                    LoadAck,
  output logic                    FrameSync,
  output logic                    SegA,
  output logic                    SegB,
  output logic                    SegC,
  output logic                    SegD,
  output logic                    SegE,
  output logic                    SegF,
  output logic                    SegG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   nDigit
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);
  localparam int IDX_W   = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  // Set by reset and by Enable low: the next BLANK exit starts a fresh frame
  // at digit 0 instead of advancing idx.
  logic               restart, restart_nxt;
  logic               boundary;
  logic               capture;

  // Shadow copy of the display contents
  logic [4*NUM_DIGITS-1:0] shadow_data, data_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, dp_nxt;
  logic [NUM_DIGITS-1:0]   shadow_blank, blank_nxt;

  // Next-cycle output values, registered below
  logic [3:0]            hex_sel;
  seg7_t                 dec_seg;
  logic                  dp_sel;
  logic                  blank_sel;
  logic                  suppress;
  logic                  drive_on;
  logic [NUM_DIGITS-1:0] ndigit_nxt;
  seg7_t                 seg_nxt;
  logic                  dp_out_nxt;
  seg7_t                 seg_q;

  // Scan state register; Enable low and reset both park the scan.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!HRESETn) begin
      state   <= BLANK;
      idx     <= '0;
      cnt     <= '0;
      restart <= 1'b1;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      restart <= restart_nxt;
    end
  end

  // Next-state logic: dwell/blank counting, digit advance and frame boundary.
  always_comb begin
    // NOTE: every variable driven here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    restart_nxt = restart;
    boundary    = 1'b0;

    if (!Enable) begin
      state_nxt   = BLANK;
      idx_nxt     = '0;
      cnt_nxt     = '0;
      restart_nxt = 1'b1;
    end else begin
      case (state)
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt   = DRIVE;
            cnt_nxt     = '0;
            restart_nxt = 1'b0;
            if (restart || (idx == IDX_LAST)) begin
              idx_nxt  = '0;
              boundary = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign capture = boundary & Load;

  // Shadow contents as they will be after this edge; outputs are computed
  // from these so the first digit of a freshly loaded frame is already new.
  always_comb begin
    data_nxt  = capture ? DigitData : shadow_data;
    dp_nxt    = capture ? DPMask    : shadow_dp;
    blank_nxt = capture ? BlankMask : shadow_blank;
  end

`ifdef LED_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;

  // Leading-zero run from the top digit down; digit 0 is never suppressed.
  // Uses the registered shadow only: the shadow changes solely on the edge
  // that enters digit 0, which suppression never affects.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run & (shadow_data[4*k +: 4] == 4'h0) & ~shadow_dp[k];
      lz_blank[k] = lz_run;
    end
  end

  assign suppress = lz_blank[idx_nxt];
`else
  assign suppress = 1'b0;
`endif

  assign hex_sel   = data_nxt[4*idx_nxt +: 4];
  assign dp_sel    = dp_nxt[idx_nxt];
  assign blank_sel = blank_nxt[idx_nxt] | suppress;

  led_hex_decoder u_hex_decoder (
    .hex (hex_sel),
    .seg (dec_seg)
  );

  // Output values for the upcoming cycle: one active-low select, or all dark.
  always_comb begin
    drive_on   = (state_nxt == DRIVE) && !blank_sel;
    ndigit_nxt = '1;
    seg_nxt    = SEG_OFF;
    dp_out_nxt = 1'b0;
    if (drive_on) begin
      ndigit_nxt[idx_nxt] = 1'b0;
      seg_nxt             = dec_seg;
      dp_out_nxt          = dp_sel;
    end
  end

  // Shadow registers and registered outputs.
  always_ff @(posedge HCLK) begin
    // NOTE: the shadow is a handful of flops rather than a RAM, so it is reset;
    // blank-all-ones keeps the display dark until the first load.
    if (!HRESETn) begin
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      nDigit       <= '1;
      seg_q        <= SEG_OFF;
      DP           <= 1'b0;
      LoadAck      <= 1'b0;
      FrameSync    <= 1'b0;
    end else begin
      shadow_data  <= data_nxt;
      shadow_dp    <= dp_nxt;
      shadow_blank <= blank_nxt;
      nDigit       <= ndigit_nxt;
      seg_q        <= seg_nxt;
      DP           <= dp_out_nxt;
      LoadAck      <= capture;
      FrameSync    <= boundary;
    end
  end

  assign SegA = seg_q.a;
  assign SegB = seg_q.b;
  assign SegC = seg_q.c;
  assign SegD = seg_q.d;
  assign SegE = seg_q.e;
  assign SegF = seg_q.f;
  assign SegG = seg_q.g;

endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench for led_scan_controller: each scenario pushes the
// per-cycle output it expects into a scoreboard queue, and every clock the
// observed outputs are popped against it.
module tb_led_scan_controller;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BW    = 1;
  localparam int FRAME = N * (DW + BW);

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic           Enable;
  logic [4*N-1:0] DigitData;
  logic [N-1:0]   DPMask;
  logic [N-1:0]   BlankMask;
  logic           Load;
  logic           LoadAck;
  logic           FrameSync;
  logic           SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP;
  logic [N-1:0]   nDigit;

  typedef struct packed {
    logic [N-1:0] ndig;
    logic [6:0]   seg;
    logic         dp;
    logic         ack;
    logic         fs;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    fs_seen, ack_seen, dp_seen;
  int    last_fs, fs_gap;
  string cur_test = "";

  // Glyphs written as gfedcba
  localparam logic [6:0] SEG_REF [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  led_scan_controller #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BW)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .Enable    (Enable),
    .DigitData (DigitData),
    .DPMask    (DPMask),
    .BlankMask (BlankMask),
    .Load      (Load),
    .LoadAck   (LoadAck),
    .FrameSync (FrameSync),
    .SegA      (SegA),
    .SegB      (SegB),
    .SegC      (SegC),
    .SegD      (SegD),
    .SegE      (SegE),
    .SegF      (SegF),
    .SegG      (SegG),
    .DP        (DP),
    .nDigit    (nDigit)
  );

  always #5 HCLK = ~HCLK;

  task automatic push_dark(input int n);
    obs_t e;
    e = '{ndig: '1, seg: '0, dp: 1'b0, ack: 1'b0, fs: 1'b0};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Expected outputs for the first n cycles of a frame showing the given data.
  task automatic push_frame(input logic [4*N-1:0] data, input logic [N-1:0] dp,
                            input logic [N-1:0] blank, input logic ack, input int n);
    obs_t         e;
    logic [N-1:0] lz;
    logic         lit;
    int           pos;
    pos = 0;
    lz  = '0;
`ifdef LED_LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int k = 0; k < N; k++) if (data[4*k +: 4] != 4'h0 || dp[k]) msd = k;
      for (int k = 1; k < N; k++) if (k > msd) lz[k] = 1'b1;
    end
`endif
    for (int k = 0; k < N; k++) begin
      lit = !blank[k] && !lz[k];
      for (int c = 0; c < DW; c++) begin
        if (pos < n) begin
          e.ndig = '1;
          if (lit) e.ndig[k] = 1'b0;
          e.seg = lit ? SEG_REF[data[4*k +: 4]] : 7'h00;
          e.dp  = lit & dp[k];
          e.ack = (pos == 0) & ack;
          e.fs  = (pos == 0);
          exp_q.push_back(e);
        end
        pos++;
      end
      for (int c = 0; c < BW; c++) begin
        if (pos < n) begin
          e = '{ndig: '1, seg: '0, dp: 1'b0, ack: 1'b0, fs: 1'b0};
          exp_q.push_back(e);
        end
        pos++;
      end
    end
  endtask

  // Advance n clocks; sample #1 after each edge against the scoreboard, then
  // act as the requester and drop Load once LoadAck is seen.
  task automatic run_cycles(input int n);
    obs_t got, e;
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
      cyc++;
      got.ndig = nDigit;
      got.seg  = {SegG, SegF, SegE, SegD, SegC, SegB, SegA};
      got.dp   = DP;
      got.ack  = LoadAck;
      got.fs   = FrameSync;
      if (got.fs === 1'b1) begin
        if (last_fs >= 0) fs_gap = cyc - last_fs;
        last_fs = cyc;
        fs_seen++;
      end
      if (got.ack === 1'b1) ack_seen++;
      if (got.dp === 1'b1) dp_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s underrun at cycle %0d: got nDigit=%b, required a scoreboard entry",
                 cur_test, cyc, got.ndig);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s cycle %0d: got nDigit=%b seg=%h dp=%b ack=%b fs=%b, required nDigit=%b seg=%h dp=%b ack=%b fs=%b",
                   cur_test, cyc, got.ndig, got.seg, got.dp, got.ack, got.fs,
                   e.ndig, e.seg, e.dp, e.ack, e.fs);
        end
      end
      #1;
      if (LoadAck === 1'b1) Load = 1'b0;
    end
  endtask

  task automatic clear_stats();
    fs_seen  = 0;
    ack_seen = 0;
    dp_seen  = 0;
    last_fs  = -1;
    fs_gap   = 0;
  endtask

  // Reset state, then one dark frame since the shadow resets to all-blank.
  task automatic test_reset();
    cur_test = "reset";
    clear_stats();
    push_dark(3);
    run_cycles(3);
    HRESETn = 1'b1;
    push_frame('0, '0, '1, 1'b0, FRAME);
    run_cycles(FRAME);
    checks++;
    if (fs_seen !== 1 || ack_seen !== 0) begin
      errors++;
      $display("FAIL reset_pulses: got fs=%0d ack=%0d, required fs=1 ack=0", fs_seen, ack_seen);
    end
  endtask

  // Load 1234 at a boundary; two frames scanning 4,3,2,1 with a 20-clock period.
  task automatic test_basic();
    cur_test = "basic_1234";
    clear_stats();
    DigitData = 16'h1234;
    DPMask    = '0;
    BlankMask = '0;
    Load      = 1'b1;
    push_frame(16'h1234, '0, '0, 1'b1, FRAME);
    push_frame(16'h1234, '0, '0, 1'b0, FRAME);
    run_cycles(2 * FRAME);
    checks++;
    if (ack_seen !== 1 || fs_seen !== 2 || fs_gap !== FRAME) begin
      errors++;
      $display("FAIL basic_pulses: got ack=%0d fs=%0d gap=%0d, required ack=1 fs=2 gap=%0d",
               ack_seen, fs_seen, fs_gap, FRAME);
    end
  endtask

  // Load raised at clock 7 of a frame: current frame keeps old data.
  task automatic test_midframe_load();
    cur_test = "midframe_load";
    clear_stats();
    push_frame(16'h1234, '0, '0, 1'b0, FRAME);
    push_frame(16'hABCD, '0, '0, 1'b1, FRAME);
    run_cycles(6);
    DigitData = 16'hABCD;
    Load      = 1'b1;
    run_cycles(2 * FRAME - 6);
    checks++;
    if (ack_seen !== 1) begin
      errors++;
      $display("FAIL midframe_ack_count: got %0d, required 1", ack_seen);
    end
  endtask

  // Digit 3 blanked, DP on digit 1, glyphs F and 5.
  task automatic test_blank_dp();
    cur_test = "blank_dp";
    clear_stats();
    DigitData = 16'h0F05;
    DPMask    = 4'b0010;
    BlankMask = 4'b1000;
    Load      = 1'b1;
    push_frame(16'h0F05, 4'b0010, 4'b1000, 1'b1, FRAME);
    push_frame(16'h0F05, 4'b0010, 4'b1000, 1'b0, FRAME);
    run_cycles(2 * FRAME);
    checks++;
    if (dp_seen !== 2 * DW) begin
      errors++;
      $display("FAIL blank_dp_count: got %0d DP cycles, required %0d", dp_seen, 2 * DW);
    end
  endtask

  // Enable dropped during digit 2 drive, then restored.
  task automatic test_enable();
    cur_test = "enable";
    push_frame(16'h0F05, 4'b0010, 4'b1000, 1'b0, 11);
    run_cycles(11);
    clear_stats();
    Enable = 1'b0;
    Load   = 1'b1;
    push_dark(5);
    run_cycles(5);
    checks++;
    if (fs_seen !== 0 || ack_seen !== 0) begin
      errors++;
      $display("FAIL enable_quiet: got fs=%0d ack=%0d while disabled, required 0 and 0",
               fs_seen, ack_seen);
    end
    Load   = 1'b0;
    Enable = 1'b1;
    push_frame(16'h0F05, 4'b0010, 4'b1000, 1'b0, FRAME);
    run_cycles(FRAME);
  endtask

  // Reset during digit 0 drive with Load held: ack at clock 1 after release.
  task automatic test_reset_midframe();
    cur_test = "reset_midframe";
    push_frame(16'h0F05, 4'b0010, 4'b1000, 1'b0, 3);
    run_cycles(3);
    clear_stats();
    HRESETn   = 1'b0;
    DigitData = 16'h1234;
    DPMask    = '0;
    BlankMask = '0;
    Load      = 1'b1;
    push_dark(2);
    run_cycles(2);
    HRESETn = 1'b1;
    push_frame(16'h1234, '0, '0, 1'b1, FRAME);
    push_frame(16'h1234, '0, '0, 1'b0, FRAME);
    run_cycles(2 * FRAME);
    checks++;
    if (ack_seen !== 1) begin
      errors++;
      $display("FAIL reset_midframe_ack: got %0d, required 1", ack_seen);
    end
  endtask

  // Leading zeros: suppressed only when the option is built in.
  task automatic test_leading_zero();
    cur_test = "leading_zero";
    DigitData = 16'h0070;
    Load      = 1'b1;
    push_frame(16'h0070, '0, '0, 1'b1, FRAME);
    run_cycles(FRAME);
    DigitData = 16'h0000;
    Load      = 1'b1;
    push_frame(16'h0000, '0, '0, 1'b1, FRAME);
    run_cycles(FRAME);
  endtask

  initial begin
    HRESETn   = 1'b0;
    Enable    = 1'b1;
    Load      = 1'b0;
    DigitData = '0;
    DPMask    = '0;
    BlankMask = '0;
    clear_stats();
    test_reset();
    test_basic();
    test_midframe_load();
    test_blank_dp();
    test_enable();
    test_reset_midframe();
    test_leading_zero();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
